coin_acceptor: RTL and testbench

Front-end coin intake stage feeding the vending controller's `amt` input. It synchronises and debounces raw coin-sensor lines and converts each clean rising edge into a coin code. Codes are buffered in a small FIFO and replayed to the controller as single-cycle `amt` pulses separated by idle (0) cycles. Coins are rejected when the buffer is full, or when two lines fire in the same cycle.

---
 rtl/coin_acceptor_pkg.sv | 24 ++
 rtl/coin_acceptor_if.sv | 32 +++
 rtl/coin_acceptor_debounce.sv | 63 ++++++
 rtl/coin_acceptor.sv | 123 ++++++++++++
 tb/tb_coin_acceptor.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coin_acceptor_pkg.sv
// +------------------------------------------------------------------+
// | coin_pkg : shared amount codes and output-FSM state encoding      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package coin_pkg;

   typedef logic [3:0] amt_t;

   localparam amt_t AMT_NONE = 4'd0;
   localparam amt_t AMT_5    = 4'd5;
   localparam amt_t AMT_10   = 4'd10;
   localparam amt_t AMT_15   = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_GAP  = 2'd2
   } out_state_t;

endpackage

`default_nettype wire

// File: rtl/coin_acceptor_if.sv
// +------------------------------------------------------------------+
// | coin_acceptor_if : sensor inputs, delivery enable and outputs     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface coin_acceptor_if #(
   parameter int FIFO_DEPTH = 4
);
   import coin_pkg::*;

   logic                        sense_5;
   logic                        sense_10;
   logic                        sense_15;
   logic                        out_en;
   amt_t                        amt;
   logic                        coin_reject;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;

   modport master (
      output sense_5, sense_10, sense_15, out_en,
      input  amt, coin_reject, fifo_level
   );

   modport slave (
      input  sense_5, sense_10, sense_15, out_en,
      output amt, coin_reject, fifo_level
   );

endinterface

`default_nettype wire

// File: rtl/coin_acceptor_debounce.sv
// +------------------------------------------------------------------+
// | coin_debounce : sync, debounce, arming and rising-edge event      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module coin_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  wire  clk,
   input  wire  reset,
   input  wire  sense,
   output logic pulse
);

   localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  C_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [1:0]    settle;
   logic [CW-1:0] cnt;
   logic          filtered;
   logic          filtered_d;
   logic          armed;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         settle     <= 2'b00;
         cnt        <= '0;
         filtered   <= 1'b0;
         filtered_d <= 1'b0;
         armed      <= 1'b0;
         pulse      <= 1'b0;
      end else begin
         sync1      <= sense;
         sync2      <= sync1;
         settle     <= {settle[0], 1'b1};
         filtered_d <= filtered;

         if (sync2 == filtered) begin
            cnt <= '0;
         end else if (cnt == C_LAST) begin
            filtered <= ~filtered;
            cnt      <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end

         // A low filtered level is only trusted once the synchroniser holds
         // post-reset samples, so a line held high through reset stays unarmed.
         if (settle[1] && !filtered && !sync2)
            armed <= 1'b1;

         pulse <= armed & filtered & ~filtered_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/coin_acceptor.sv
// +------------------------------------------------------------------+
// | coin_acceptor : debounced coin intake, FIFO, spaced amt replay    |
// | Option macro COIN_ACCEPTOR_15_EN enables the 15-unit line. Rev 1.0|
// +------------------------------------------------------------------+
`default_nettype none

module coin_acceptor
   import coin_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4
) (
   input wire              clk,
   input wire              reset,
   coin_acceptor_if.slave  bus
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic       ev5;
   logic       ev10;
   logic       ev15;

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db5 (
      .clk(clk), .reset(reset), .sense(bus.sense_5), .pulse(ev5)
   );

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db10 (
      .clk(clk), .reset(reset), .sense(bus.sense_10), .pulse(ev10)
   );

`ifdef COIN_ACCEPTOR_15_EN
   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db15 (
      .clk(clk), .reset(reset), .sense(bus.sense_15), .pulse(ev15)
   );
`else
   logic unused_sense_15;
   assign unused_sense_15 = bus.sense_15;
   assign ev15            = 1'b0;
`endif

   logic       multi;
   logic       single;
   logic       full;
   logic       empty;
   logic       push;
   logic       pop;
   amt_t       code;
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] level;
   amt_t       mem [FIFO_DEPTH];
   out_state_t state;
   amt_t       amt_q;
   logic       reject_q;

   always_comb begin
      multi  = (ev5 & ev10) | (ev5 & ev15) | (ev10 & ev15);
      single = (ev5 | ev10 | ev15) & ~multi;
      code   = ev5 ? AMT_5 : (ev10 ? AMT_10 : AMT_15);
      empty  = (wr_ptr == rd_ptr);
      full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      pop    = (state == ST_IDLE) && bus.out_en && !empty;
      // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
      push   = single & (~full | pop);
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= code;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         reject_q <= 1'b0;
         amt_q    <= AMT_NONE;
         state    <= ST_IDLE;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase

         reject_q <= multi | (single & ~push);

         case (state)
            ST_IDLE: begin
               amt_q <= AMT_NONE;
               if (pop) begin
                  amt_q <= mem[rd_ptr[AW-1:0]];
                  state <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               amt_q <= AMT_NONE;
               state <= ST_GAP;
            end
            ST_GAP: begin
               amt_q <= AMT_NONE;
               state <= ST_IDLE;
            end
            default: begin
               amt_q <= AMT_NONE;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.amt         = amt_q;
   assign bus.coin_reject = reject_q;
   assign bus.fifo_level  = level;

endmodule

`default_nettype wire

// File: tb/tb_coin_acceptor.sv
// +------------------------------------------------------------------+
// | tb_coin_acceptor : directed self-checking bench for coin_acceptor |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_coin_acceptor;
   import coin_pkg::*;

`ifdef COIN_ACCEPTOR_15_EN
   localparam int EXP15_PULSES = 1;
   localparam int EXP15_VAL    = 15;
`else
   localparam int EXP15_PULSES = 0;
   localparam int EXP15_VAL    = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   coin_acceptor_if #(.FIFO_DEPTH(4)) bus ();

   coin_acceptor #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cycle   = 0;
   int reject_count = 0;
   int pulse_cycle[$];
   int pulse_val[$];

   always @(posedge clk) cycle++;

   always @(negedge clk) begin
      if (bus.amt != 4'd0) begin
         pulse_cycle.push_back(cycle);
         pulse_val.push_back(int'(bus.amt));
      end
      if (bus.coin_reject) reject_count++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      bus.sense_5  = 1'b0;
      bus.sense_10 = 1'b0;
      bus.sense_15 = 1'b0;
      bus.out_en   = 1'b0;
      tick(3);
      n_tests++;
      if (bus.amt !== 4'd0) begin
         n_fail++; $display("FAIL reset_amt: got %0d expected 0", bus.amt);
      end
      n_tests++;
      if (bus.coin_reject !== 1'b0) begin
         n_fail++; $display("FAIL reset_reject: got %b expected 0", bus.coin_reject);
      end
      n_tests++;
      if (bus.fifo_level !== 3'd0) begin
         n_fail++; $display("FAIL reset_level: got %0d expected 0", bus.fifo_level);
      end
      reset = 1'b0;
      tick(4);
   endtask

   task automatic test_single_coin();
      int base = pulse_val.size();
      bus.out_en   = 1'b1;
      bus.sense_10 = 1'b1;
      tick(7);
      n_tests++;
      if (bus.fifo_level !== 3'd0) begin
         n_fail++; $display("FAIL single_level_e6: got %0d expected 0", bus.fifo_level);
      end
      tick(1);
      n_tests++;
      if (bus.fifo_level !== 3'd1 || bus.amt !== 4'd0) begin
         n_fail++; $display("FAIL single_e7: level %0d amt %0d expected level 1 amt 0", bus.fifo_level, bus.amt);
      end
      tick(1);
      n_tests++;
      if (bus.amt !== 4'd10 || bus.fifo_level !== 3'd0) begin
         n_fail++; $display("FAIL single_e8: amt %0d level %0d expected amt 10 level 0", bus.amt, bus.fifo_level);
      end
      tick(1);
      n_tests++;
      if (bus.amt !== 4'd0) begin
         n_fail++; $display("FAIL single_e9_amt: got %0d expected 0", bus.amt);
      end
      bus.sense_10 = 1'b0;
      tick(12);
      n_tests++;
      if (pulse_val.size() - base != 1) begin
         n_fail++; $display("FAIL single_pulse_count: got %0d expected 1", pulse_val.size() - base);
      end
   endtask

   task automatic test_glitch();
      int base_p = pulse_val.size();
      int base_r = reject_count;
      bus.out_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.sense_5 = ~bus.sense_5;
         tick(1);
      end
      bus.sense_5 = 1'b0;
      tick(20);
      n_tests++;
      if (pulse_val.size() - base_p != 0) begin
         n_fail++; $display("FAIL glitch_pulses: got %0d expected 0", pulse_val.size() - base_p);
      end
      n_tests++;
      if (reject_count - base_r != 0) begin
         n_fail++; $display("FAIL glitch_rejects: got %0d expected 0", reject_count - base_r);
      end
   endtask

   task automatic test_fifo_full();
      int base_p = pulse_val.size();
      int base_r = reject_count;
      bus.out_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.sense_5 = 1'b1;
         tick(8);
         bus.sense_5 = 1'b0;
         tick(8);
      end
      n_tests++;
      if (bus.fifo_level !== 3'd4) begin
         n_fail++; $display("FAIL full_level: got %0d expected 4", bus.fifo_level);
      end
      n_tests++;
      if (reject_count - base_r != 1) begin
         n_fail++; $display("FAIL full_rejects: got %0d expected 1", reject_count - base_r);
      end
      n_tests++;
      if (pulse_val.size() - base_p != 0) begin
         n_fail++; $display("FAIL full_stalled_pulses: got %0d expected 0", pulse_val.size() - base_p);
      end
      bus.out_en = 1'b1;
      tick(20);
      n_tests++;
      if (pulse_val.size() - base_p != 4) begin
         n_fail++; $display("FAIL drain_pulses: got %0d expected 4", pulse_val.size() - base_p);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (pulse_val[base_p + i] != 5) begin
            n_fail++; $display("FAIL drain_val%0d: got %0d expected 5", i, pulse_val[base_p + i]);
         end
      end
      for (int i = 1; i < 4; i++) begin
         n_tests++;
         if (pulse_cycle[base_p + i] - pulse_cycle[base_p + i - 1] != 3) begin
            n_fail++; $display("FAIL drain_spacing%0d: got %0d expected 3", i,
                               pulse_cycle[base_p + i] - pulse_cycle[base_p + i - 1]);
         end
      end
      n_tests++;
      if (bus.fifo_level !== 3'd0) begin
         n_fail++; $display("FAIL drain_level: got %0d expected 0", bus.fifo_level);
      end
   endtask

   task automatic test_simultaneous();
      int base_p = pulse_val.size();
      int base_r = reject_count;
      bus.out_en   = 1'b1;
      bus.sense_5  = 1'b1;
      bus.sense_10 = 1'b1;
      tick(7);
      n_tests++;
      if (bus.coin_reject !== 1'b0) begin
         n_fail++; $display("FAIL simul_reject_e6: got %b expected 0", bus.coin_reject);
      end
      tick(1);
      n_tests++;
      if (bus.coin_reject !== 1'b1) begin
         n_fail++; $display("FAIL simul_reject_e7: got %b expected 1", bus.coin_reject);
      end
      bus.sense_5  = 1'b0;
      bus.sense_10 = 1'b0;
      tick(12);
      n_tests++;
      if (reject_count - base_r != 1) begin
         n_fail++; $display("FAIL simul_rejects: got %0d expected 1", reject_count - base_r);
      end
      n_tests++;
      if (pulse_val.size() - base_p != 0 || bus.fifo_level !== 3'd0) begin
         n_fail++; $display("FAIL simul_no_coin: pulses %0d level %0d expected 0 and 0",
                            pulse_val.size() - base_p, bus.fifo_level);
      end
   endtask

   task automatic test_held_reset();
      int base_p;
      bus.out_en  = 1'b1;
      bus.sense_5 = 1'b1;
      apply_reset();
      base_p = pulse_val.size();
      tick(20);
      n_tests++;
      if (pulse_val.size() - base_p != 0 || bus.fifo_level !== 3'd0) begin
         n_fail++; $display("FAIL held_no_coin: pulses %0d level %0d expected 0 and 0",
                            pulse_val.size() - base_p, bus.fifo_level);
      end
      bus.sense_5 = 1'b0;
      tick(10);
      bus.sense_5 = 1'b1;
      tick(15);
      n_tests++;
      if (pulse_val.size() - base_p != 1) begin
         n_fail++; $display("FAIL held_rearm_pulses: got %0d expected 1", pulse_val.size() - base_p);
      end
      n_tests++;
      if (pulse_val[base_p] != 5) begin
         n_fail++; $display("FAIL held_rearm_val: got %0d expected 5", pulse_val[base_p]);
      end
      bus.sense_5 = 1'b0;
      tick(10);
   endtask

   task automatic test_reset_mid();
      int base_p;
      bus.out_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.sense_10 = 1'b1;
         tick(8);
         bus.sense_10 = 1'b0;
         tick(8);
      end
      n_tests++;
      if (bus.fifo_level !== 3'd2) begin
         n_fail++; $display("FAIL mid_level_before: got %0d expected 2", bus.fifo_level);
      end
      apply_reset();
      n_tests++;
      if (bus.fifo_level !== 3'd0) begin
         n_fail++; $display("FAIL mid_level_after: got %0d expected 0", bus.fifo_level);
      end
      base_p     = pulse_val.size();
      bus.out_en = 1'b1;
      tick(10);
      n_tests++;
      if (pulse_val.size() - base_p != 0) begin
         n_fail++; $display("FAIL mid_lost_coins: got %0d pulses expected 0", pulse_val.size() - base_p);
      end
   endtask

   task automatic test_coin_15();
      int base_p = pulse_val.size();
      int got_val;
      bus.out_en   = 1'b1;
      bus.sense_15 = 1'b1;
      tick(10);
      bus.sense_15 = 1'b0;
      tick(10);
      n_tests++;
      if (pulse_val.size() - base_p != EXP15_PULSES) begin
         n_fail++; $display("FAIL coin15_pulses: got %0d expected %0d", pulse_val.size() - base_p, EXP15_PULSES);
      end
      got_val = (pulse_val.size() > base_p) ? pulse_val[base_p] : 0;
      n_tests++;
      if (got_val != EXP15_VAL) begin
         n_fail++; $display("FAIL coin15_val: got %0d expected %0d", got_val, EXP15_VAL);
      end
   endtask

   initial begin
      test_reset();
      test_single_coin();
      test_glitch();
      test_fifo_full();
      test_simultaneous();
      test_held_reset();
      test_reset_mid();
      test_coin_15();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

`default_nettype wire
